// File: rtl/equiv_sweep_checker.sv
// Clocked equivalence checker: sweeps every N_IN-bit pattern into two implementations
// of one function and records the mismatch count, the first failing pattern and pass.
module equiv_sweep_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] x,
    input  logic            a_in,
    input  logic            b_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_count,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] X_LAST   = '1;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   x_q, x_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_IN:0]     mm_q, mm_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              ffv_q, ffv_d;
    logic              pass_q, pass_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            mm_q    <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            mm_q    <= mm_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        mm_d    = mm_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = APPLY;
                    x_d     = '0;
                    cnt_d   = '0;
                    mm_d    = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SAMPLE: begin
                if (a_in != b_in) begin
                    mm_d = mm_q + (N_IN + 1)'(1);
                    if (!ffv_q) begin
                        ff_d  = x_q;
                        ffv_d = 1'b1;
                    end
                end
                // pass is taken from the count including this last sample
                if (x_q == X_LAST) begin
                    state_d = DONE;
                    pass_d  = (mm_d == '0);
                end else begin
                    x_d     = x_q + N_IN'(1);
                    state_d = APPLY;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy             = (state_q == APPLY) || (state_q == SAMPLE);
        done             = (state_q == DONE);
        x                = x_q;
        pass             = pass_q;
        mismatch_count   = mm_q;
        first_fail       = ff_q;
        first_fail_valid = ffv_q;
    end

endmodule
